hamm_rx_deser: RTL and testbench

Serial front end for the Hamming(7,4) error-correction stage. It recovers UART-style framed 7-bit codewords from a single-wire bit stream and holds each codeword in an output register. The codeword drives the corrector's 7-bit d_hamm input through a valid/ready handshake. Sits directly upstream of the corrector; one codeword per frame.

---
 rtl/hamm_rx_deser.sv | 109 ++++++++++
 tb/tb_hamm_rx_deser.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hamm_rx_deser.sv
// hamm_rx_deser: recovers framed 7-bit Hamming codewords from a serial line into a valid/ready output register
// Ports: clk (rising edge), rst_n (async, active-low), ser_in (serial line, idles high),
//   d_hamm/hamm_valid/hamm_ready (codeword handshake), frame_err (one-cycle stop-bit error pulse),
//   overrun (sticky, set when a good frame is dropped), ovr_clr (synchronous clear of overrun).
// Option: define RX_SYNC_EN to pass ser_in through a 2-flop synchronizer (all sample points 2 cycles later).
module hamm_rx_deser #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    output logic [6:0] d_hamm,
    output logic       hamm_valid,
    input  logic       hamm_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT * 9);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, bit_pt;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sh_q, sh_d, dat_q, dat_d;
    logic          vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d, hi_q, hi_d;
    logic          rx, at_start, at_bit, deliver, drop;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], ser_in};
    assign rx = sync_q[1];
`else
    assign rx = ser_in;
`endif

    // The counter is cleared on the start-detect edge, so it reads (cycle - 1) at the edge of a given cycle.
    // bit_q indexes the next sample: 0..6 data bits, 7 the stop bit.
    assign at_start = cnt_q == CW'(HALF - 1);
    assign bit_pt   = CW'(HALF + (32'(bit_q) + 32'd1) * CLKS_PER_BIT - 1);
    assign at_bit   = cnt_q == bit_pt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
        // Requiring the raw pin high as well keeps the synchronizer's reset value from counting as line-high.
        hi_d    = hi_q | (rx & ser_in);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (hi_q && !rx) state_d = START;
            end
            START: if (at_start) state_d = rx ? IDLE : DATA;
            DATA: if (at_bit) begin
                sh_d  = {rx, sh_q[6:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd6) state_d = STOP;
            end
            STOP: if (at_bit) begin
                state_d = IDLE;
                deliver = rx;
                ferr_d  = !rx;
            end
            default: state_d = IDLE;
        endcase
        drop  = deliver & vld_q & !hamm_ready;
        dat_d = (deliver && !drop) ? sh_q : dat_q;
        vld_d = (deliver & !drop) | (vld_q & !hamm_ready);
        ovr_d = drop | (ovr_q & !ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            hi_q    <= hi_d;
        end
    end

    assign d_hamm     = dat_q;
    assign hamm_valid = vld_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_hamm_rx_deser.sv
// tb_hamm_rx_deser: directed and randomized frames checked every cycle against a behavioural output model
module tb_hamm_rx_deser;
    localparam int N = 16;
    localparam int H = N / 2;
`ifdef RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int STOP_C = H + 8 * N + LAT;

    logic       clk = 1'b0, rst_n = 1'b0, ser_in = 1'b1, hamm_ready = 1'b0, ovr_clr = 1'b0;
    logic [6:0] d_hamm;
    logic       hamm_valid, frame_err, overrun;
    logic [6:0] m_d = '0;
    logic       m_v = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    int         checks = 0, errors = 0;
    bit         rnd = 1'b0;

    hamm_rx_deser #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .d_hamm(d_hamm), .hamm_valid(hamm_valid),
        .hamm_ready(hamm_ready), .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_d_hamm"}, d_hamm, m_d);
        chk({tag, "_valid"}, 7'(hamm_valid), 7'(m_v));
        chk({tag, "_frame_err"}, 7'(frame_err), 7'(m_fe));
        chk({tag, "_overrun"}, 7'(overrun), 7'(m_ov));
    endtask

    // One clock edge: the model applies the delivery/handshake/overrun rules, then outputs are compared.
    task automatic tick(input bit stop_edge, input bit stop_ok, input logic [6:0] data, input string tag);
        bit r, oc, del, drp;
        if (rnd) begin
            hamm_ready = 1'($urandom_range(0, 1));
            ovr_clr    = ($urandom_range(0, 31) == 0);
        end
        r  = hamm_ready;
        oc = ovr_clr;
        @(posedge clk);
        if (!rst_n) begin
            m_d = '0; m_v = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        end else begin
            del  = stop_edge & stop_ok;
            drp  = del & m_v & !r;
            m_ov = drp | (m_ov & !oc);
            m_fe = stop_edge & !stop_ok;
            if (del && !drp) begin
                m_d = data;
                m_v = 1'b1;
            end else if (m_v && r) m_v = 1'b0;
        end
        #1;
        check_out(tag);
    endtask

    task automatic idle(input int n, input string tag);
        ser_in = 1'b1;
        repeat (n) tick(1'b0, 1'b0, 7'h0, tag);
    endtask

    task automatic low(input int n, input string tag);
        ser_in = 1'b0;
        repeat (n) tick(1'b0, 1'b0, 7'h0, tag);
    endtask

    // Drives cycles 0..cut-1 of a frame; rs pulses hamm_ready only on the stop-sample edge.
    task automatic frame(input logic [6:0] data, input bit stop_bit, input bit rs, input int cut, input string tag);
        logic [8:0] fr;
        int k;
        fr = {stop_bit, data, 1'b0};
        for (int c = 0; c < cut; c++) begin
            k = c / N;
            ser_in = fr[k[3:0]];
            if (rs) hamm_ready = (c == STOP_C);
            tick(c == STOP_C, stop_bit, data, tag);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_out("reset");
        rst_n = 1'b1;
        idle(5, "post_reset");

        hamm_ready = 1'b1;
        frame(7'b1010101, 1'b1, 1'b0, 9 * N, "t1");
        idle(4, "t1_after");
        chk("t1_data", d_hamm, 7'h55);

        low(4, "t2_pulse");
        idle(150, "t2_idle");
        frame(7'h0F, 1'b1, 1'b0, 9 * N, "t2");
        idle(3, "t2_after");
        chk("t2_data", d_hamm, 7'h0F);

        frame(7'h33, 1'b0, 1'b0, 9 * N, "t3");
        idle(5, "t3_after");
        chk("t3_data_kept", d_hamm, 7'h0F);

        hamm_ready = 1'b0;
        frame(7'h12, 1'b1, 1'b0, 9 * N, "t4a");
        frame(7'h6D, 1'b1, 1'b0, 9 * N, "t4b");
        idle(3, "t4_held");
        chk("t4_data_held", d_hamm, 7'h12);
        chk("t4_overrun_set", 7'(overrun), 7'h1);
        ovr_clr = 1'b1;
        tick(1'b0, 1'b0, 7'h0, "t4_clr");
        ovr_clr = 1'b0;
        idle(2, "t4_cleared");
        hamm_ready = 1'b1;
        idle(2, "t4_drain");

        hamm_ready = 1'b0;
        frame(7'h01, 1'b1, 1'b0, 9 * N, "t5a");
        frame(7'h7E, 1'b1, 1'b1, 9 * N, "t5b");
        idle(3, "t5_after");
        chk("t5_data", d_hamm, 7'h7E);
        hamm_ready = 1'b1;
        idle(2, "t5_drain");

        hamm_ready = 1'b0;
        frame(7'h11, 1'b1, 1'b0, 9 * N, "t6a");
        frame(7'h22, 1'b1, 1'b0, 9 * N, "t6b");
        frame(7'h55, 1'b1, 1'b0, 4 * N + H, "t6_cut");
        rst_n = 1'b0;
        m_d = '0; m_v = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        #1;
        check_out("t6_async_rst");
        low(5, "t6_in_rst");
        rst_n = 1'b1;
        low(150, "t6_line_low");
        idle(5, "t6_line_high");
        frame(7'h2A, 1'b1, 1'b0, 9 * N, "t6");
        idle(3, "t6_after");
        chk("t6_data", d_hamm, 7'h2A);
        hamm_ready = 1'b1;
        idle(2, "t6_drain");

        rnd = 1'b1;
        for (int i = 0; i < 25; i++) begin
            idle($urandom_range(1, 20), "rnd_gap");
            frame(7'($urandom), ($urandom_range(0, 4) != 0), 1'b0, 9 * N, "rnd");
        end
        rnd = 1'b0;
        ovr_clr = 1'b0;
        hamm_ready = 1'b1;
        idle(4, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
